// File: rtl/packet_arbiter_rr_pkg.sv
// Shared types for the packet arbiter slice: the AXI-Stream beat layout,
// the routing-header TID value and a small helper used by the arbiter.
package packet_arbiter_rr_pkg;

  localparam int TDATA_WIDTH = 32;
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int TID_WIDTH   = 4;
  localparam int TDEST_WIDTH = 4;
  localparam int TUSER_WIDTH = 1;

  // One AXI-Stream beat as it travels through the router.
  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
  } axis_data_t;

  // TID value that marks the first (routing header) beat of every packet.
  localparam logic [TID_WIDTH-1:0] ROUTING_HEADER = 4'hA;

  // True when the beat carries the routing-header TID.
  function automatic logic is_header(input axis_data_t beat);
    return beat.tid == ROUTING_HEADER;
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_picker.sv
// Combinational round-robin priority picker: returns the first asserted
// request found when scanning from ptr upward, wrapping from N-1 to 0.
module rr_priority_picker #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);

  int cand;

  // Scan N candidates starting at ptr; the first hit wins and later hits are ignored.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any_req && req[W'(cand)]) begin
        any_req = 1'b1;
        winner  = W'(cand);
      end
    end
  end

endmodule

// File: rtl/packet_arbiter_rr.sv
// Per-output-channel packet arbiter. Shares one AXI-Stream output among
// INPUT_NUMBER requesters, round-robin, holding the grant from the routing
// header beat through TLAST. Also keeps packet and stall PMU counters.
//
// Handshake semantics (all stream ports): a beat moves on a rising clk edge
// exactly when valid && ready are both high in that cycle. A source keeps its
// beat and valid stable until that happens; ready may toggle freely and valid
// never depends on ready. Here out_valid depends only on the lock state and the
// granted in_valid, and in_ready[grant_idx] is a pass-through of out_ready.
module packet_arbiter_rr
  import packet_arbiter_rr_pkg::*;
#(
  parameter int INPUT_NUMBER       = 10,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER),
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  axis_data_t                    in [INPUT_NUMBER],
  input  logic [INPUT_NUMBER-1:0]       in_valid,
  output logic [INPUT_NUMBER-1:0]       in_ready,
  output axis_data_t                    out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INPUT_NUMBER_WIDTH-1:0] grant_idx,
  output logic                          grant_valid,
  output logic                          proto_err,
  input  logic                          cnt_clear,
  output logic [COUNTER_WIDTH-1:0]      pkt_count,
  output logic [COUNTER_WIDTH-1:0]      stall_count,
  output logic                          state_dbg,
  output logic [INPUT_NUMBER_WIDTH-1:0] rr_ptr_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [INPUT_NUMBER_WIDTH-1:0] LAST_IDX = INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);

  arb_state_e                    state, state_nxt;
  logic [INPUT_NUMBER_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [INPUT_NUMBER_WIDTH-1:0] grant_nxt;
  logic                          first_beat, first_beat_nxt;

  logic [INPUT_NUMBER_WIDTH-1:0] winner;
  logic                          any_req;
  logic                          handshake;

  rr_priority_picker #(
    .N (INPUT_NUMBER),
    .W (INPUT_NUMBER_WIDTH)
  ) u_picker (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Arbiter state register: lock state, round-robin pointer, grant and header tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      first_beat <= 1'b1;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_idx  <= grant_nxt;
      first_beat <= first_beat_nxt;
    end
  end

  // Next-state and datapath muxing. IDLE only arbitrates (one bubble per
  // packet); LOCKED forwards the granted requester until its TLAST handshake.
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    grant_nxt      = grant_idx;
    first_beat_nxt = first_beat;
    out            = '0;
    out_valid      = 1'b0;
    in_ready       = '0;
    grant_valid    = 1'b0;
    handshake      = 1'b0;
    proto_err      = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt      = winner;
          state_nxt      = LOCKED;
          first_beat_nxt = 1'b1;
        end
      end

      LOCKED: begin
        grant_valid         = 1'b1;
        out                 = in[grant_idx];
        out_valid           = in_valid[grant_idx];
        in_ready[grant_idx] = out_ready;
        handshake           = out_valid && out_ready;
        // Flag a lock whose opening beat is not a routing header; the beat still passes.
        proto_err           = handshake && first_beat && !is_header(out);
        if (handshake) begin
          first_beat_nxt = 1'b0;
          if (out.tlast) begin
            state_nxt      = IDLE;
            first_beat_nxt = 1'b1;
            rr_ptr_nxt     = (grant_idx == LAST_IDX) ? '0
                                                     : grant_idx + INPUT_NUMBER_WIDTH'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PMU counters: completed packets and output back-pressure cycles; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (cnt_clear) begin
        pkt_count <= '0;
      end else if (handshake && out.tlast) begin
        pkt_count <= pkt_count + COUNTER_WIDTH'(1);
      end

      if (cnt_clear) begin
        stall_count <= '0;
      end else if (out_valid && !out_ready) begin
        stall_count <= stall_count + COUNTER_WIDTH'(1);
      end
    end
  end

  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Directed bench for packet_arbiter_rr: reset, round-robin order, stalls,
// pointer wrap, header protocol flag, counter clear and mid-packet reset.
module tb_packet_arbiter_rr;
  import packet_arbiter_rr_pkg::*;

  localparam int N  = 10;
  localparam int IW = $clog2(N);
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  axis_data_t      in_beats [N];
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  axis_data_t      out;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;
  logic            proto_err;
  logic            cnt_clear;
  logic [CW-1:0]   pkt_count;
  logic [CW-1:0]   stall_count;
  logic            state_dbg;
  logic [IW-1:0]   rr_ptr_dbg;

  int n_checks = 0;
  int n_errors = 0;

  packet_arbiter_rr #(
    .INPUT_NUMBER       (N),
    .INPUT_NUMBER_WIDTH (IW),
    .COUNTER_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in_beats),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .proto_err   (proto_err),
    .cnt_clear   (cnt_clear),
    .pkt_count   (pkt_count),
    .stall_count (stall_count),
    .state_dbg   (state_dbg),
    .rr_ptr_dbg  (rr_ptr_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver helpers
  function automatic axis_data_t mk(input logic [31:0] d, input logic [3:0] id, input logic last);
    axis_data_t b;
    b       = '0;
    b.tdata = d;
    b.tkeep = '1;
    b.tid   = id;
    b.tlast = last;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int beat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    for (int i = 0; i < N; i++) in_beats[i] = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid",   64'(out_valid),   64'h0);
    check_eq("rst_in_ready",    64'(in_ready),    64'h0);
    check_eq("rst_grant_valid", 64'(grant_valid), 64'h0);
    check_eq("rst_pkt",         64'(pkt_count),   64'h0);
    check_eq("rst_stall",       64'(stall_count), 64'h0);
    check_eq("rst_rr_ptr",      64'(rr_ptr_dbg),  64'h0);
    check_eq("rst_out_data",    64'(out.tdata),   64'h0);
    tick();
    rst_n = 1'b1;

    // ---- inputs 2 and 7 together, rr_ptr=0 ----
    in_beats[2] = mk(32'h200, ROUTING_HEADER, 1'b0); in_valid[2] = 1'b1;
    in_beats[7] = mk(32'h700, ROUTING_HEADER, 1'b1); in_valid[7] = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    check_eq("t2_idle_out_valid", 64'(out_valid), 64'h0);
    check_eq("t2_idle_in_ready",  64'(in_ready),  64'h0);
    tick();
    @(negedge clk);
    check_eq("t2_grant_valid", 64'(grant_valid), 64'h1);
    check_eq("t2_grant_idx",   64'(grant_idx),   64'h2);
    check_eq("t2_out_valid",   64'(out_valid),   64'h1);
    check_eq("t2_beat0",       64'(out.tdata),   64'h200);
    check_eq("t2_in_ready",    64'(in_ready),    64'h004);
    check_eq("t2_no_proto",    64'(proto_err),   64'h0);
    tick();
    in_beats[2] = mk(32'h201, 4'h0, 1'b1);
    @(negedge clk);
    check_eq("t2_beat1",  64'(out.tdata), 64'h201);
    check_eq("t2_tlast",  64'(out.tlast), 64'h1);
    tick();
    in_valid[2] = 1'b0;
    @(negedge clk);
    check_eq("t2_released", 64'(grant_valid), 64'h0);
    check_eq("t2_rr_ptr",   64'(rr_ptr_dbg),  64'h3);
    check_eq("t2_pkt",      64'(pkt_count),   64'h1);
    tick();
    @(negedge clk);
    check_eq("t2_grant7",   64'(grant_idx), 64'h7);
    check_eq("t2_beat7",    64'(out.tdata), 64'h700);
    tick();
    in_valid[7] = 1'b0;

    // ---- input 3 four beats with out_ready 1010.., input 5 waiting ----
    in_beats[3] = mk(32'h300, ROUTING_HEADER, 1'b0); in_valid[3] = 1'b1;
    in_beats[5] = mk(32'h500, ROUTING_HEADER, 1'b1); in_valid[5] = 1'b1;
    @(negedge clk);
    check_eq("t3_rr_ptr",     64'(rr_ptr_dbg), 64'h8);
    check_eq("t3_pkt",        64'(pkt_count),  64'h2);
    check_eq("t3_idle_ready", 64'(in_ready),   64'h0);
    tick();
    beat = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = (k % 2 == 0);
      @(negedge clk);
      check_eq("t3_grant",    64'(grant_idx), 64'h3);
      check_eq("t3_data",     64'(out.tdata), 64'(32'h300 + beat));
      check_eq("t3_in_ready", 64'(in_ready),  (k % 2 == 0) ? 64'h008 : 64'h000);
      tick();
      if (k % 2 == 0) begin
        beat++;
        if (beat < 4) in_beats[3] = mk(32'h300 + beat, 4'h0, beat == 3);
        else          in_valid[3] = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("t3_stall",  64'(stall_count), 64'h3);
    check_eq("t3_pkt1",   64'(pkt_count),   64'h3);
    check_eq("t3_rr_ptr4", 64'(rr_ptr_dbg), 64'h4);
    tick();
    @(negedge clk);
    check_eq("t3_grant5",  64'(grant_idx), 64'h5);
    check_eq("t3_beat5",   64'(out.tdata), 64'h500);
    check_eq("t3_ready5",  64'(in_ready),  64'h020);
    tick();
    in_valid[5] = 1'b0;

    // ---- input 9 single beat, pointer wraps ----
    in_beats[9] = mk(32'h900, ROUTING_HEADER, 1'b1); in_valid[9] = 1'b1;
    @(negedge clk);
    check_eq("t4_rr_ptr6", 64'(rr_ptr_dbg), 64'h6);
    tick();
    @(negedge clk);
    check_eq("t4_grant9", 64'(grant_idx), 64'h9);
    check_eq("t4_beat9",  64'(out.tdata), 64'h900);
    tick();
    in_valid[9] = 1'b0;

    // ---- input 1 opens with a non-header TID ----
    in_beats[1] = mk(32'h100, 4'h3, 1'b0); in_valid[1] = 1'b1;
    @(negedge clk);
    check_eq("t4_wrap",    64'(rr_ptr_dbg),  64'h0);
    check_eq("t4_pkt",     64'(pkt_count),   64'h5);
    check_eq("t4_release", 64'(grant_valid), 64'h0);
    tick();
    @(negedge clk);
    check_eq("t5_grant1",    64'(grant_idx), 64'h1);
    check_eq("t5_proto_err", 64'(proto_err), 64'h1);
    check_eq("t5_fwd_valid", 64'(out_valid), 64'h1);
    check_eq("t5_fwd_data",  64'(out.tdata), 64'h100);
    tick();
    in_beats[1] = mk(32'h101, 4'h3, 1'b1);
    @(negedge clk);
    check_eq("t5_proto_once", 64'(proto_err), 64'h0);
    check_eq("t5_beat1",      64'(out.tdata), 64'h101);
    tick();
    in_valid[1] = 1'b0;

    // ---- cnt_clear coincident with a TLAST handshake ----
    in_beats[4] = mk(32'h400, ROUTING_HEADER, 1'b1); in_valid[4] = 1'b1;
    @(negedge clk);
    check_eq("t6_pkt_before", 64'(pkt_count),  64'h6);
    check_eq("t6_rr_ptr2",    64'(rr_ptr_dbg), 64'h2);
    tick();
    cnt_clear = 1'b1;
    @(negedge clk);
    check_eq("t6_grant4", 64'(grant_idx), 64'h4);
    tick();
    cnt_clear   = 1'b0;
    in_valid[4] = 1'b0;

    // ---- mid-packet asynchronous reset ----
    in_beats[6] = mk(32'h600, ROUTING_HEADER, 1'b0); in_valid[6] = 1'b1;
    @(negedge clk);
    check_eq("t6_pkt_cleared",   64'(pkt_count),   64'h0);
    check_eq("t6_stall_cleared", 64'(stall_count), 64'h0);
    check_eq("t6_rr_ptr5",       64'(rr_ptr_dbg),  64'h5);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("t1_grant6",   64'(grant_idx), 64'h6);
    check_eq("t1_no_ready", 64'(in_ready),  64'h0);
    tick();
    @(negedge clk);
    check_eq("t1_stall1", 64'(stall_count), 64'h1);
    check_eq("t1_locked", 64'(grant_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t1_rst_in_ready",  64'(in_ready),    64'h0);
    check_eq("t1_rst_out_valid", 64'(out_valid),   64'h0);
    check_eq("t1_rst_grant",     64'(grant_valid), 64'h0);
    check_eq("t1_rst_stall",     64'(stall_count), 64'h0);
    check_eq("t1_rst_pkt",       64'(pkt_count),   64'h0);
    check_eq("t1_rst_rr_ptr",    64'(rr_ptr_dbg),  64'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_rearb_idle", 64'(out_valid), 64'h0);
    tick();
    @(negedge clk);
    check_eq("t1_rearb_grant", 64'(grant_idx), 64'h6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
